// File: rtl/vga_sram_responder.sv
// rtl/vga_sram_responder.sv - Wishbone slave driving an asynchronous 128Kx16 video SRAM
//
// One 16-bit word access at a time, no pipelining, programmable wait states.
// Every output is a register; the FSM computes next values combinationally.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   wb_adr_i[17:1]    word address from the arbiter master port
//   wb_sel_i[1:0]     byte lane selects, [1]=upper, [0]=lower
//   wb_we_i           1=write
//   wb_dat_i          write data
//   wb_dat_o          registered read data (holds between reads)
//   wb_stb_i/cyc_i    request; accepted only in IDLE with both high
//   wb_ack_o          registered one-cycle acknowledge
//   sram_addr_o       SRAM address
//   sram_dat_i/_o/_oe SRAM data pad in/out and output enable (1=drive)
//   sram_ce_n/oe_n/we_n/ub_n/lb_n  active-low SRAM strobes

module vga_sram_responder #(
    parameter int unsigned RD_WAIT = 1,
    parameter int unsigned WR_WAIT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [17:1] wb_adr_i,
    input  logic [1:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic [16:0] sram_addr_o,
    input  logic [15:0] sram_dat_i,
    output logic [15:0] sram_dat_o,
    output logic        sram_dat_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD       = 3'd1,
        S_WR_SETUP = 3'd2,
        S_WR_PULSE = 3'd3,
        S_WR_HOLD  = 3'd4,
        S_ACK      = 3'd5
    } state_t;

    localparam logic [3:0] RD_LOAD = 4'(RD_WAIT);
    localparam logic [3:0] WR_LOAD = 4'(WR_WAIT);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;

    logic        ack_nxt;
    logic [15:0] rdat_nxt;
    logic [16:0] addr_nxt;
    logic [15:0] wdat_nxt;
    logic        doe_nxt;
    logic        ce_n_nxt;
    logic        oe_n_nxt;
    logic        we_n_nxt;
    logic        ub_n_nxt;
    logic        lb_n_nxt;

    logic        req;
    logic [15:0] rd_masked;

    assign req = wb_cyc_i & wb_stb_i;

    // Byte lanes whose enable is still high at capture time were not selected
    // and read back as zero.
    assign rd_masked = {sram_ub_n ? 8'h00 : sram_dat_i[15:8],
                        sram_lb_n ? 8'h00 : sram_dat_i[7:0]};

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            wb_ack_o    <= 1'b0;
            wb_dat_o    <= 16'h0000;
            sram_addr_o <= 17'h00000;
            sram_dat_o  <= 16'h0000;
            sram_dat_oe <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_ub_n   <= 1'b1;
            sram_lb_n   <= 1'b1;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            wb_ack_o    <= ack_nxt;
            wb_dat_o    <= rdat_nxt;
            sram_addr_o <= addr_nxt;
            sram_dat_o  <= wdat_nxt;
            sram_dat_oe <= doe_nxt;
            sram_ce_n   <= ce_n_nxt;
            sram_oe_n   <= oe_n_nxt;
            sram_we_n   <= we_n_nxt;
            sram_ub_n   <= ub_n_nxt;
            sram_lb_n   <= lb_n_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (req) begin
                    state_nxt = wb_we_i ? S_WR_SETUP : S_RD;
                end
            end
            S_RD: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_ACK;
                end
            end
            S_WR_SETUP: state_nxt = S_WR_PULSE;
            S_WR_PULSE: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_WR_HOLD;
                end
            end
            S_WR_HOLD:  state_nxt = S_ACK;
            S_ACK:      state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and the wait counter
    always_comb begin
        cnt_nxt  = cnt;
        ack_nxt  = 1'b0;
        rdat_nxt = wb_dat_o;
        addr_nxt = sram_addr_o;
        wdat_nxt = sram_dat_o;
        doe_nxt  = sram_dat_oe;
        ce_n_nxt = sram_ce_n;
        oe_n_nxt = sram_oe_n;
        we_n_nxt = sram_we_n;
        ub_n_nxt = sram_ub_n;
        lb_n_nxt = sram_lb_n;

        unique case (state)
            S_IDLE: begin
                if (req) begin
                    addr_nxt = wb_adr_i;
                    ub_n_nxt = ~wb_sel_i[1];
                    lb_n_nxt = ~wb_sel_i[0];
                    wdat_nxt = wb_dat_i;
                    ce_n_nxt = 1'b0;
                    if (wb_we_i) begin
                        doe_nxt = 1'b1;
                    end else begin
                        oe_n_nxt = 1'b0;
                        cnt_nxt  = RD_LOAD;
                    end
                end
            end
            S_RD: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    rdat_nxt = rd_masked;
                    ce_n_nxt = 1'b1;
                    oe_n_nxt = 1'b1;
                    ub_n_nxt = 1'b1;
                    lb_n_nxt = 1'b1;
                    ack_nxt  = 1'b1;
                end
            end
            S_WR_SETUP: begin
                // Address and data have been stable for one cycle; open the pulse.
                we_n_nxt = 1'b0;
                cnt_nxt  = WR_LOAD;
            end
            S_WR_PULSE: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    we_n_nxt = 1'b1;
                end
            end
            S_WR_HOLD: begin
                // Data stayed on the pad one cycle past the rising we_n edge.
                doe_nxt  = 1'b0;
                ce_n_nxt = 1'b1;
                ub_n_nxt = 1'b1;
                lb_n_nxt = 1'b1;
                ack_nxt  = 1'b1;
            end
            S_ACK: begin
                ack_nxt = 1'b0;
            end
            default: begin
                ack_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_vga_sram_responder.sv
// tb/tb_vga_sram_responder.sv - scoreboard bench for vga_sram_responder at three wait-state builds

module tb_vga_sram_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [17:1] adr;
    logic [1:0]  sel;
    logic        we;
    logic [15:0] dat;
    logic        cyc;
    logic        stb      [3];

    logic [15:0] wbdat_a  [3];
    logic        ack_a    [3];
    logic [16:0] addr_a   [3];
    logic [15:0] sdi_a    [3];
    logic [15:0] sdo_a    [3];
    logic        doe_a    [3];
    logic        ce_a     [3];
    logic        oe_a     [3];
    logic        we_a     [3];
    logic        ub_a     [3];
    logic        lb_a     [3];

    int errors = 0;
    int checks = 0;

    vga_sram_responder u0 (
        .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_sel_i(sel), .wb_we_i(we),
        .wb_dat_i(dat), .wb_dat_o(wbdat_a[0]), .wb_stb_i(stb[0]), .wb_cyc_i(cyc),
        .wb_ack_o(ack_a[0]), .sram_addr_o(addr_a[0]), .sram_dat_i(sdi_a[0]),
        .sram_dat_o(sdo_a[0]), .sram_dat_oe(doe_a[0]), .sram_ce_n(ce_a[0]),
        .sram_oe_n(oe_a[0]), .sram_we_n(we_a[0]), .sram_ub_n(ub_a[0]), .sram_lb_n(lb_a[0])
    );

    vga_sram_responder #(.RD_WAIT(0), .WR_WAIT(0)) u1 (
        .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_sel_i(sel), .wb_we_i(we),
        .wb_dat_i(dat), .wb_dat_o(wbdat_a[1]), .wb_stb_i(stb[1]), .wb_cyc_i(cyc),
        .wb_ack_o(ack_a[1]), .sram_addr_o(addr_a[1]), .sram_dat_i(sdi_a[1]),
        .sram_dat_o(sdo_a[1]), .sram_dat_oe(doe_a[1]), .sram_ce_n(ce_a[1]),
        .sram_oe_n(oe_a[1]), .sram_we_n(we_a[1]), .sram_ub_n(ub_a[1]), .sram_lb_n(lb_a[1])
    );

    vga_sram_responder #(.RD_WAIT(15), .WR_WAIT(15)) u2 (
        .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_sel_i(sel), .wb_we_i(we),
        .wb_dat_i(dat), .wb_dat_o(wbdat_a[2]), .wb_stb_i(stb[2]), .wb_cyc_i(cyc),
        .wb_ack_o(ack_a[2]), .sram_addr_o(addr_a[2]), .sram_dat_i(sdi_a[2]),
        .sram_dat_o(sdo_a[2]), .sram_dat_oe(doe_a[2]), .sram_ce_n(ce_a[2]),
        .sram_oe_n(oe_a[2]), .sram_we_n(we_a[2]), .sram_ub_n(ub_a[2]), .sram_lb_n(lb_a[2])
    );

    function automatic int rdw(input int i);
        return (i == 0) ? 1 : (i == 1) ? 0 : 15;
    endfunction

    function automatic int wrw(input int i);
        return (i == 0) ? 1 : (i == 1) ? 0 : 15;
    endfunction

    // SRAM pad model, one 256-word bank per DUT (address aliases on low 8 bits)
    logic [15:0] mem [3][256];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!we_a[i] && !ce_a[i] && doe_a[i]) begin
                if (!ub_a[i]) mem[i][addr_a[i][7:0]][15:8] <= sdo_a[i][15:8];
                if (!lb_a[i]) mem[i][addr_a[i][7:0]][7:0]  <= sdo_a[i][7:0];
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_rd
        assign sdi_a[g] = (!ce_a[g] && !oe_a[g]) ? mem[g][addr_a[g][7:0]] : 16'hDEAD;
    end

    typedef struct packed {
        logic [1:0]  idx;
        logic [15:0] data;
    } exp_t;

    exp_t        q [$];
    logic [15:0] exp_mem [3][256];
    logic [15:0] last_rd [3];

    int we_lo_cnt [3] = '{default: 0};
    int oe_lo_cnt [3] = '{default: 0};
    int doe_cnt   [3] = '{default: 0};
    int ack_cnt   [3] = '{default: 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: pad-level protocol, pulse counters and scoreboard pop on ack
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                check($sformatf("oe_and_drive_u%0d", i), {31'b0, !oe_a[i] && doe_a[i]}, 32'd0);
                if (!we_a[i]) begin
                    check($sformatf("we_ctx_u%0d", i), {30'b0, ce_a[i], doe_a[i]}, 32'd1);
                end
                if (!we_a[i])  we_lo_cnt[i]++;
                if (!oe_a[i])  oe_lo_cnt[i]++;
                if (doe_a[i])  doe_cnt[i]++;
                if (ack_a[i]) begin
                    exp_t e;
                    ack_cnt[i]++;
                    if (q.size() == 0) begin
                        check($sformatf("extra_ack_u%0d", i), {31'b0, ack_a[i]}, 32'd0);
                    end else begin
                        e = q.pop_front();
                        check("ack_dut", i, {30'b0, e.idx});
                        check($sformatf("rdata_u%0d", i), {16'b0, wbdat_a[i]}, {16'b0, e.data});
                    end
                end
            end
        end
    end

    task automatic chk_reset(input int i, input string tag);
        check({tag, "_ack"},  {31'b0, ack_a[i]},  32'd0);
        check({tag, "_wdat"}, {16'b0, wbdat_a[i]}, 32'd0);
        check({tag, "_addr"}, {15'b0, addr_a[i]}, 32'd0);
        check({tag, "_sdo"},  {16'b0, sdo_a[i]},  32'd0);
        check({tag, "_doe"},  {31'b0, doe_a[i]},  32'd0);
        check({tag, "_strb"}, {27'b0, ce_a[i], oe_a[i], we_a[i], ub_a[i], lb_a[i]}, 32'h1f);
    endtask

    // One access on DUT i; keep=1 holds strobe through the edge after acceptance
    task automatic req(input int i, input logic w, input logic [16:0] a, input logic [1:0] s,
                       input logic [15:0] d, input int keep);
        int lat, we0, oe0, doe0;
        logic [15:0] rexp;
        exp_t e;
        @(negedge clk);
        adr = a; sel = s; we = w; dat = d; cyc = 1'b1; stb[i] = 1'b1;
        if (w) begin
            if (s[1]) exp_mem[i][a[7:0]][15:8] = d[15:8];
            if (s[0]) exp_mem[i][a[7:0]][7:0]  = d[7:0];
            e.data = last_rd[i];
        end else begin
            rexp[15:8] = s[1] ? exp_mem[i][a[7:0]][15:8] : 8'h00;
            rexp[7:0]  = s[0] ? exp_mem[i][a[7:0]][7:0]  : 8'h00;
            last_rd[i] = rexp;
            e.data = rexp;
        end
        e.idx = 2'(i);
        q.push_back(e);
        we0 = we_lo_cnt[i]; oe0 = oe_lo_cnt[i]; doe0 = doe_cnt[i];
        @(posedge clk);
        if (keep == 0) begin
            #1; stb[i] = 1'b0; cyc = 1'b0;
        end
        lat = 99;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (j == 1) begin
                check("sram_addr", {15'b0, addr_a[i]}, {15'b0, a});
                check("byte_en", {30'b0, ub_a[i], lb_a[i]}, {30'b0, ~s});
            end
            if (j == 2 && keep != 0) begin
                stb[i] = 1'b0; cyc = 1'b0;
            end
            if (ack_a[i]) begin
                lat = j;
                break;
            end
        end
        check($sformatf("latency_u%0d_%s", i, w ? "wr" : "rd"), lat, w ? wrw(i) + 4 : rdw(i) + 2);
        @(negedge clk);
        check("we_low_cycles",  we_lo_cnt[i] - we0, w ? wrw(i) + 1 : 0);
        check("oe_low_cycles",  oe_lo_cnt[i] - oe0, w ? 0 : rdw(i) + 1);
        check("drive_cycles",   doe_cnt[i] - doe0,  w ? wrw(i) + 3 : 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, prev, a0;
        rst = 1'b1; adr = '0; sel = '0; we = 1'b0; dat = '0; cyc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stb[i] = 1'b0;
            last_rd[i] = 16'h0000;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset(0, "por_u0");
        chk_reset(2, "por_u2");
        rst = 1'b0;

        // Default build: full-word write then read back
        req(0, 1'b1, 17'h1ABCD, 2'b11, 16'h55AA, 0);
        req(0, 1'b0, 17'h1ABCD, 2'b11, 16'h0000, 0);
        // Lane handling
        req(0, 1'b1, 17'h00010, 2'b11, 16'h1234, 0);
        req(0, 1'b0, 17'h00010, 2'b10, 16'h0000, 0);
        req(0, 1'b1, 17'h00010, 2'b01, 16'hFFEE, 0);
        req(0, 1'b0, 17'h00010, 2'b11, 16'h0000, 1);
        req(0, 1'b1, 17'h00010, 2'b00, 16'h0000, 1);
        req(0, 1'b0, 17'h00010, 2'b00, 16'h0000, 0);
        req(0, 1'b0, 17'h00010, 2'b11, 16'h0000, 0);

        // Strobe held across three reads
        @(negedge clk);
        a0 = ack_cnt[0];
        adr = 17'h1ABCD; sel = 2'b11; we = 1'b0; cyc = 1'b1; stb[0] = 1'b1;
        for (int k = 0; k < 3; k++) q.push_back('{idx: 2'd0, data: exp_mem[0][8'hCD]});
        last_rd[0] = exp_mem[0][8'hCD];
        n = 0; prev = -1;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (ack_a[0]) begin
                if (prev >= 0) check("b2b_gap_ok", {31'b0, (j - prev) >= 2}, 32'd1);
                prev = j;
                n++;
                if (n == 3) begin
                    stb[0] = 1'b0; cyc = 1'b0;
                    break;
                end
            end
        end
        repeat (10) @(negedge clk);
        check("b2b_ack_count", ack_cnt[0] - a0, 3);

        // Zero-wait build
        req(1, 1'b1, 17'h00020, 2'b11, 16'hA5C3, 0);
        req(1, 1'b0, 17'h00020, 2'b11, 16'h0000, 0);
        // Maximum-wait build
        req(2, 1'b1, 17'h00030, 2'b11, 16'h0F0F, 0);
        req(2, 1'b0, 17'h00030, 2'b01, 16'h0000, 0);

        // Reset in the middle of a write pulse
        @(negedge clk);
        a0 = ack_cnt[0];
        adr = 17'h00077; sel = 2'b11; we = 1'b1; dat = 16'hBEEF; cyc = 1'b1; stb[0] = 1'b1;
        @(posedge clk);
        #1; stb[0] = 1'b0; cyc = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("pulse_active", {31'b0, we_a[0]}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_edge_strb", {29'b0, we_a[0], ce_a[0], doe_a[0]}, 32'h6);
        check("rst_edge_ack", {31'b0, ack_a[0]}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset(0, "rst3_u0");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) last_rd[i] = 16'h0000;
        repeat (10) @(negedge clk);
        check("rst_no_ack", ack_cnt[0] - a0, 0);

        // Still functional after the abort
        req(0, 1'b0, 17'h1ABCD, 2'b11, 16'h0000, 0);
        repeat (4) @(negedge clk);
        check("scoreboard_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
